uart_tx_fifo: RTL and testbench

- Elastic byte buffer between the UART receiver and the UART transmitter.
- Accepts single-cycle byte strobes from the receiver and stores them in a circular FIFO.
- A drain FSM issues one tx_start pulse per byte and honours the transmitter's tx_busy handshake, so back-to-back received bytes are never lost while a transmission is in flight.
- Replaces direct data_ready-to-tx_start wiring in echo and loopback paths.

---
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Elastic byte FIFO between the UART receiver and transmitter, drained by a tx_start/tx_busy FSM.
// Define UART_TX_FIFO_STATS_EN to add the saturating drop_cnt output.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  input  logic                   wr_frame_err,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [TW-1:0]     timer;
  state_t            state;
  logic              push;
  logic              pop;
  logic              ovf_drop;
  logic [CW-1:0]     count_next;

  // The FSM looks only at registered empty, so a push into an empty FIFO cannot pop the same cycle.
  always_comb begin
    pop        = (state == S_IDLE) && !empty && !tx_busy;
    push       = wr_valid && !wr_frame_err && (!full || pop);
    ovf_drop   = wr_valid && !wr_frame_err && full && !pop;
    count_next = count + CW'(push) - CW'(pop);
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
      if (ovf_drop) overflow <= 1'b1;
    end
  end

  // NOTE: tx_start gets a default low first and is overridden later in the same block; with
  // non-blocking assignments the last write wins, which yields an exact one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      rd_ptr   <= '0;
      timer    <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
            timer    <= '0;
            state    <= S_WAIT_RISE;
          end
        end
        S_WAIT_RISE: begin
          // A transmitter that never acknowledges must not stall the queue; the byte counts as sent.
          if (tx_busy) state <= S_WAIT_FALL;
          else if (timer == TW'(BUSY_TIMEOUT - 1)) state <= S_IDLE;
          else timer <= timer + TW'(1);
        end
        S_WAIT_FALL: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic frame_drop;
  assign frame_drop = wr_valid && wr_frame_err;

  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= '0;
    else if ((frame_drop || ovf_drop) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a transmitter model answers tx_start with a tx_busy window,
// a monitor logs every launched byte, and each scenario task compares the log with its expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH        = 16;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_frame_err;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [$clog2(DEPTH):0] count;
  logic              empty;
  logic              full;
  logic              overflow;
`ifdef UART_TX_FIFO_STATS_EN
  logic [7:0]        drop_cnt;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_frame_err(wr_frame_err),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int proto_viol = 0;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_cyc[$];
  logic [7:0] sb_exp;
  logic [7:0] sb_got;

  // Transmitter model: busy for busy_len cycles after it samples tx_start; hold_busy forces it busy.
  logic model_en = 1'b1;
  logic hold_busy = 1'b0;
  logic model_busy = 1'b0;
  int busy_len = 3;
  int busy_left = 0;
  assign tx_busy = model_busy | hold_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else if (model_en && tx_start && !model_busy) begin
      model_busy <= 1'b1;
      busy_left  <= busy_len;
    end else if (model_busy) begin
      if (busy_left <= 1) model_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset && tx_start) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
      if (tx_busy || prev_start) proto_viol++;
    end
    prev_start = tx_start;
  end

  // Drives a one-cycle receiver strobe; called and returns on a falling edge.
  task automatic strobe(input logic [7:0] d, input logic fe);
    wr_data      = d;
    wr_frame_err = fe;
    wr_valid     = 1'b1;
    @(negedge clk);
    wr_valid     = 1'b0;
    wr_frame_err = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s launches: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_busy || !empty) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s idle: transmitter/fifo still busy after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_frame_err = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data: got %h expected 00", tx_data); end
    if (count !== 5'd0) begin errors++; $display("FAIL reset count: got %0d expected 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b expected 1", empty); end
    if (full !== 1'b0) begin errors++; $display("FAIL reset full: got %b expected 0", full); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", overflow); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    busy_len = 3;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    exp_q.push_back(8'h41);
    strobe(8'h41, 1'b0);
    checks += 2;
    if (count !== 5'd1) begin errors++; $display("FAIL single count N+1: got %0d expected 1", count); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single early start: got %b expected 0", tx_start); end
    @(negedge clk);
    checks += 3;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL single start N+2: got %b expected 1", tx_start); end
    if (tx_data !== 8'h41) begin errors++; $display("FAIL single tx_data: got %h expected 41", tx_data); end
    if (count !== 5'd0) begin errors++; $display("FAIL single count after pop: got %0d expected 0", count); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single pulse width: got %b expected 0", tx_start); end
    wait_drain("single", 20);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL single data: got %h expected %h", sb_got, sb_exp); end
    end
    wait_idle("single");
  endtask

  task automatic test_burst();
    busy_len = 100;
    proto_viol = 0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      strobe(8'h10 + 8'(i), 1'b0);
    end
    wait_drain("burst", 5 * 120);
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] - got_cyc[i-1] <= busy_len) begin
        errors++;
        $display("FAIL burst spacing %0d: got %0d cycles, required more than %0d", i, got_cyc[i] - got_cyc[i-1], busy_len);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL burst data: got %h expected %h", sb_got, sb_exp); end
    end
    checks++;
    if (proto_viol !== 0) begin errors++; $display("FAIL burst handshake: got %0d violations expected 0", proto_viol); end
    wait_idle("burst");
    busy_len = 3;
  endtask

  task automatic test_overflow();
    hold_busy = 1'b1;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) exp_q.push_back(8'h20 + 8'(i));
      strobe(8'h20 + 8'(i), 1'b0);
    end
    checks += 3;
    if (full !== 1'b1) begin errors++; $display("FAIL overflow full: got %b expected 1", full); end
    if (count !== 5'(DEPTH)) begin errors++; $display("FAIL overflow count: got %0d expected %0d", count, DEPTH); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b expected 1", overflow); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL overflow drop_cnt: got %0d expected 2", drop_cnt); end
`endif
    hold_busy = 1'b0;
    wait_drain("overflow", DEPTH * 12 + 20);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL overflow data: got %h expected %h", sb_got, sb_exp); end
    end
    wait_idle("overflow");
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold_busy = 1'b1;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h60 + 8'(i));
      strobe(8'h60 + 8'(i), 1'b0);
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_pop precondition full: got %b expected 1", full); end
    hold_busy = 1'b0;
    exp_q.push_back(8'hAA);
    strobe(8'hAA, 1'b0);
    checks += 4;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL full_pop launch: got %b expected 1", tx_start); end
    if (count !== 5'(DEPTH)) begin errors++; $display("FAIL full_pop count: got %0d expected %0d", count, DEPTH); end
    if (full !== 1'b1) begin errors++; $display("FAIL full_pop full: got %b expected 1", full); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop overflow: got %b expected 0", overflow); end
    wait_drain("full_pop", (DEPTH + 1) * 12 + 20);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL full_pop data: got %h expected %h", sb_got, sb_exp); end
    end
    wait_idle("full_pop");
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop overflow end: got %b expected 0", overflow); end
  endtask

  task automatic test_frame_err();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    strobe(8'h55, 1'b1);
    repeat (6) @(negedge clk);
    checks += 3;
    if (count !== 5'd0) begin errors++; $display("FAIL frame_err count: got %0d expected 0", count); end
    if (got_q.size() != 0) begin errors++; $display("FAIL frame_err launches: got %0d expected 0", got_q.size()); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL frame_err overflow: got %b expected 0", overflow); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL frame_err drop_cnt: got %0d expected 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    busy_len = 100;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 4; i++) strobe(8'hC0 + 8'(i), 1'b0);
    repeat (5) @(negedge clk);
    checks += 2;
    if (got_q.size() != 1 || got_q[0] !== 8'hC0) begin
      errors++; $display("FAIL reset_mid first byte: got %0d launches, expected 1 of c0", got_q.size());
    end
    if (count !== 5'd3) begin errors++; $display("FAIL reset_mid queued: got %0d expected 3", count); end
    reset = 1'b1;
    @(negedge clk);
    checks += 5;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_mid count: got %0d expected 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_mid empty: got %b expected 1", empty); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_mid tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_mid tx_data: got %h expected 00", tx_data); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_mid overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    busy_len = 3;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    @(negedge clk);
    exp_q.push_back(8'h77);
    strobe(8'h77, 1'b0);
    @(negedge clk);
    checks += 2;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL reset_mid relaunch: got %b expected 1", tx_start); end
    if (tx_data !== 8'h77) begin errors++; $display("FAIL reset_mid relaunch data: got %h expected 77", tx_data); end
    wait_drain("reset_mid", 20);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL reset_mid data: got %h expected %h", sb_got, sb_exp); end
    end
    wait_idle("reset_mid");
  endtask

  task automatic test_timeout();
    model_en = 1'b0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    strobe(8'h81, 1'b0);
    strobe(8'h82, 1'b0);
    wait_drain("timeout", 40);
    checks++;
    if (got_cyc.size() < 2) begin
      errors++; $display("FAIL timeout gap: got %0d launches, expected 2", got_cyc.size());
    end else if (got_cyc[1] - got_cyc[0] != BUSY_TIMEOUT + 1) begin
      errors++; $display("FAIL timeout gap: got %0d cycles expected %0d", got_cyc[1] - got_cyc[0], BUSY_TIMEOUT + 1);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      sb_exp = exp_q.pop_front(); sb_got = got_q.pop_front(); checks++;
      if (sb_got !== sb_exp) begin errors++; $display("FAIL timeout data: got %h expected %h", sb_got, sb_exp); end
    end
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_frame_err();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
